// File: rtl/maroc_sc_sequencer.sv
// MAROC slow-control sequencer: reset pulse, frame load and serial shift.
// An optional second load/shift pass compares the readback against the transmitted frame.
module maroc_sc_sequencer #(
    parameter int unsigned FRAME_LEN  = 829,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic       CK_in,
    input  logic       RSTn,
    input  logic       start,
    input  logic       verify_en,
    input  logic       abort,
    input  logic       d_tx,
    input  logic       sr_q,
    output logic       ld,
    output logic       sh,
    output logic       ck_en,
    output logic       RSTn_SC,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [9:0] mism_cnt,
    output logic [9:0] bit_cnt
);

    localparam int unsigned CW = 10;
    localparam int unsigned PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] MISM_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_LOAD1,
        S_SHIFT1,
        S_LOAD2,
        S_SHIFT2,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          verify_q, verify_d;
    logic [CW-1:0] mism_q, mism_d;
    logic          err_q, err_d;
    logic          ld_q, sh_q, ck_en_q, rstn_sc_q, busy_q, done_q;
    logic          last_bit;

    assign last_bit = (pos_q == PW'(FRAME_LEN - 1));

    // Next-state, pass counters and readback mismatch accounting
    always_comb begin
        state_d  = state_q;
        pos_d    = '0;
        rcnt_d   = '0;
        verify_d = verify_q;
        mism_d   = mism_q;
        err_d    = err_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_RESET;
                        verify_d = verify_en;
                        mism_d   = '0;
                        err_d    = 1'b0;
                    end
                end
                S_RESET: begin
                    if (rcnt_q == RW'(RST_CYCLES - 1)) begin
                        state_d = S_LOAD1;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                S_LOAD1: state_d = S_SHIFT1;
                S_SHIFT1: begin
                    if (last_bit) begin
                        state_d = verify_q ? S_LOAD2 : S_DONE;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
                S_LOAD2: state_d = S_SHIFT2;
                S_SHIFT2: begin
                    if ((sr_q != d_tx) && (mism_q != MISM_MAX)) begin
                        mism_d = mism_q + CW'(1);
                    end
                    if (last_bit) begin
                        state_d = S_DONE;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            // err uses mism_d so a mismatch on the final bit is included
            if (state_d == S_DONE) begin
                err_d = (mism_d != '0);
            end
        end
    end

    // Outputs are decoded from the next state so they align with the state they describe
    always_ff @(posedge CK_in or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            rcnt_q    <= '0;
            verify_q  <= 1'b0;
            mism_q    <= '0;
            err_q     <= 1'b0;
            ld_q      <= 1'b0;
            sh_q      <= 1'b0;
            ck_en_q   <= 1'b0;
            rstn_sc_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            rcnt_q    <= rcnt_d;
            verify_q  <= verify_d;
            mism_q    <= mism_d;
            err_q     <= err_d;
            ld_q      <= (state_d == S_LOAD1) || (state_d == S_LOAD2);
            sh_q      <= (state_d == S_SHIFT1) || (state_d == S_SHIFT2);
            ck_en_q   <= (state_d == S_SHIFT1) || (state_d == S_SHIFT2);
            rstn_sc_q <= (state_d != S_RESET);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign ld       = ld_q;
    assign sh       = sh_q;
    assign ck_en    = ck_en_q;
    assign RSTn_SC  = rstn_sc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mism_cnt = mism_q;
    assign bit_cnt  = CW'(pos_q);

endmodule

// File: tb/tb_maroc_sc_sequencer.sv
// Bench for maroc_sc_sequencer: table-driven runs and random runs against a cycle-timeline model.
module tb_maroc_sc_sequencer;

    localparam int R  = 4;
    localparam int F  = 829;
    localparam int FB = 1100;

    typedef struct packed {
        logic       ld;
        logic       sh;
        logic       ck_en;
        logic       rstn_sc;
        logic       busy;
        logic       done;
        logic       err;
        logic [9:0] mism;
        logic [9:0] bitc;
    } obs_t;

    typedef struct {
        bit v;
        int mode;         // 0 loopback, 1 flip bits 0/400/828, 2 always inverted, 3 random
        int abort_at;     // cycle abort is high, -1 none
        int extra_start;  // cycle of an extra start pulse, -1 none
        int exp_done_t;   // -1: no done expected
        int exp_mism;     // -1: final value not tabled
        bit exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, start, verify_en, abort, d_tx, sr_q;
    logic ld, sh, ck_en, rstn_sc, busy, done, err;
    logic [9:0] mism_cnt, bit_cnt;

    logic start_b, verify_b, abort_b, d_tx_b, sr_q_b;
    logic ld_b, sh_b, ck_en_b, rstn_sc_b, busy_b, done_b, err_b;
    logic [9:0] mism_b, bit_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maroc_sc_sequencer dut (
        .CK_in(clk), .RSTn(rst_n), .start(start), .verify_en(verify_en), .abort(abort),
        .d_tx(d_tx), .sr_q(sr_q), .ld(ld), .sh(sh), .ck_en(ck_en), .RSTn_SC(rstn_sc),
        .busy(busy), .done(done), .err(err), .mism_cnt(mism_cnt), .bit_cnt(bit_cnt)
    );

    maroc_sc_sequencer #(.FRAME_LEN(FB), .RST_CYCLES(R)) dut_big (
        .CK_in(clk), .RSTn(rst_n), .start(start_b), .verify_en(verify_b), .abort(abort_b),
        .d_tx(d_tx_b), .sr_q(sr_q_b), .ld(ld_b), .sh(sh_b), .ck_en(ck_en_b), .RSTn_SC(rstn_sc_b),
        .busy(busy_b), .done(done_b), .err(err_b), .mism_cnt(mism_b), .bit_cnt(bit_b)
    );

    function automatic obs_t sample();
        return obs_t'({ld, sh, ck_en, rstn_sc, busy, done, err, mism_cnt, bit_cnt});
    endfunction

    task automatic check_obs(input string name, input int t, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s t=%0d got{ld,sh,ck,rsc,busy,done,err,mism,bit}=%b %b %b %b %b %b %b %0d %0d required=%b %b %b %b %b %b %b %0d %0d",
                         name, t, got.ld, got.sh, got.ck_en, got.rstn_sc, got.busy, got.done, got.err,
                         got.mism, got.bitc, exp.ld, exp.sh, exp.ck_en, exp.rstn_sc, exp.busy,
                         exp.done, exp.err, exp.mism, exp.bitc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Timeline of a run started in cycle 0: phases laid end to end by their lengths
    function automatic obs_t model(input int t, input bit v, input int mism, input int abort_at);
        obs_t o;
        int   endt;
        int   s1;
        int   s2;
        endt      = v ? R + 2 * F + 3 : R + F + 2;
        s1        = R + 2;
        s2        = R + F + 3;
        o         = '0;
        o.rstn_sc = 1'b1;
        o.mism    = 10'((mism > 1023) ? 1023 : mism);
        if (abort_at >= 0 && t > abort_at) return o;
        o.busy    = (t >= 1) && (t <= endt);
        o.rstn_sc = !((t >= 1) && (t <= R));
        o.ld      = (t == R + 1) || (v && t == R + F + 2);
        if (t >= s1 && t < s1 + F) begin
            o.sh = 1'b1; o.ck_en = 1'b1; o.bitc = 10'(t - s1);
        end
        if (v && t >= s2 && t < s2 + F) begin
            o.sh = 1'b1; o.ck_en = 1'b1; o.bitc = 10'(t - s2);
        end
        o.done = (t == endt);
        o.err  = (t >= endt) && (mism != 0);
        return o;
    endfunction

    // Entered just after a rising edge; that cycle is cycle 0 of the run
    task automatic run_seq(input vec_t vc, input string name);
        int   endt, last_t, s2, mism, done_n, done_t;
        obs_t got;
        endt   = vc.v ? R + 2 * F + 3 : R + F + 2;
        last_t = (vc.abort_at >= 0) ? vc.abort_at + 4 : endt + 3;
        s2     = R + F + 3;
        mism   = 0;
        done_n = 0;
        done_t = -1;
        got    = '0;
        for (int t = 0; t <= last_t; t++) begin
            start     = (t == 0) || (t == vc.extra_start);
            verify_en = (t == 0) ? vc.v : 1'($urandom);
            abort     = (t == vc.abort_at);
            d_tx      = 1'($urandom);
            case (vc.mode)
                0:       sr_q = d_tx;
                1:       sr_q = d_tx ^ ((t == s2) || (t == s2 + 400) || (t == s2 + 828));
                2:       sr_q = ~d_tx;
                default: sr_q = 1'($urandom);
            endcase
            @(negedge clk);
            got = sample();
            if (t > 0) check_obs(name, t, got, model(t, vc.v, mism, vc.abort_at));
            if (got.done) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            if (vc.v && t >= s2 && t < s2 + F && !(vc.abort_at >= 0 && t >= vc.abort_at) && d_tx != sr_q)
                mism++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        check_int({name, " done_cycle"}, done_t, vc.exp_done_t);
        check_int({name, " done_pulses"}, done_n, (vc.exp_done_t >= 0) ? 1 : 0);
        if (vc.exp_mism >= 0) begin
            check_int({name, " final_mism"}, int'(got.mism), vc.exp_mism);
            check_int({name, " final_err"}, int'(got.err), int'(vc.exp_err));
        end
    endtask

    vec_t tbl[7];
    obs_t rst_obs, e, got;

    initial begin
        tbl[0] = '{0, 0, -1,  -1,  835,   0, 0};
        tbl[1] = '{1, 0, -1,  -1, 1665,   0, 0};
        tbl[2] = '{1, 1, -1,  -1, 1665,   3, 1};
        tbl[3] = '{0, 3, 106, -1,   -1,   0, 0};
        tbl[4] = '{0, 0, -1,  300,  835,  0, 0};
        tbl[5] = '{1, 2, 1000, -1,  -1, 164, 0};
        tbl[6] = '{1, 2, -1,  -1, 1665, 829, 1};

        rst_obs = '0;
        rst_obs.rstn_sc = 1'b1;

        rst_n = 1'b0; start = 0; verify_en = 0; abort = 0; d_tx = 0; sr_q = 0;
        start_b = 0; verify_b = 0; abort_b = 0; d_tx_b = 0; sr_q_b = 1;
        #12;
        check_obs("reset_values", 0, sample(), rst_obs);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_seq(tbl[i], $sformatf("table%0d", i));

        // start and abort together in IDLE: abort wins, last result held
        start = 1'b1; abort = 1'b1; verify_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd829, 10'd0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_obs("idle_start_abort", i, sample(), e);
            @(posedge clk); #1;
        end

        // asynchronous reset while in SHIFT2
        start = 1'b1; verify_en = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            d_tx = 1'($urandom); sr_q = ~d_tx;
            @(posedge clk); #1;
            start = 1'b0;
        end
        got = sample();
        check_int("pre_reset_sh", int'(got.sh), 1);
        check_int("pre_reset_mism", int'(got.mism), 164);
        rst_n = 1'b0;
        #1;
        check_obs("async_reset", 1000, sample(), rst_obs);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_obs("after_reset_idle", 1001, sample(), rst_obs);
        @(posedge clk); #1;
        run_seq(tbl[0], "post_reset_run");

        // saturation on the 1100-bit instance
        begin
            int dt;
            int bm;
            int be;
            dt = -1; bm = -1; be = -1;
            start_b = 1'b1; verify_b = 1'b1;
            for (int t = 0; t <= R + 2 * FB + 10; t++) begin
                @(negedge clk);
                if (done_b && dt < 0) begin
                    dt = t; bm = int'(mism_b); be = int'(err_b);
                end
                @(posedge clk); #1;
                start_b = 1'b0;
            end
            check_int("sat_done_cycle", dt, R + 2 * FB + 3);
            check_int("sat_mism", bm, 1023);
            check_int("sat_err", be, 1);
        end

        for (int k = 0; k < 4; k++) begin
            vec_t rv;
            int   endt;
            rv.v    = 1'($urandom);
            endt    = rv.v ? R + 2 * F + 3 : R + F + 2;
            rv.mode = 3;
            rv.abort_at    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, endt - 1)) : -1;
            rv.extra_start = (rv.abort_at < 0) ? int'($urandom_range(1, endt)) : -1;
            rv.exp_done_t  = (rv.abort_at < 0) ? endt : -1;
            rv.exp_mism    = -1;
            rv.exp_err     = 1'b0;
            run_seq(rv, $sformatf("random%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
